// File: rtl/main_memory.sv
// -----------------------------------------------------------------------------
// main_memory
// Data-side memory subsystem for the RISC-V core: word-organised RAM with
// byte/halfword/word access plus a memory-mapped IO page that holds a 32-bit
// LED register and an 8N1 UART transmitter.
//
// Address map:
//   address[31] = 0 : RAM, word index address[log2(DEPTH_WORDS)+1:2] (aliases)
//   address[31] = 1 : IO page
//     offset 0x0-0x3 : LED / UART data word (stores update LEDs, kick UART)
//     offset 0x4-0x7 : status word {31'b0, uart_busy}
//     other offsets  : stores ignored, loads return 0
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   address      in   [31:0] byte address
//   data_in      in   [31:0] store data, right-aligned
//   write_en     in   store request
//   read_en      in   load request
//   func3        in   [2:0] RISC-V funct3 width/sign code
//   data_out     out  [31:0] registered, extended load result
//   valid        out  one-cycle pulse the cycle after any request
//   led_display  out  [31:0] LED register
//   uart_output  out  UART TX line (idle high)
//   uart_busy    out  high while a UART frame is in flight
// -----------------------------------------------------------------------------
module main_memory #(
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    CLKS_PER_BIT = 100,
  parameter string INIT_FILE    = "main_mem.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [2:0]  func3,
  output logic [31:0] data_out,
  output logic        valid,
  output logic [31:0] led_display,
  output logic        uart_output,
  output logic        uart_busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic          w_is_io, w_io_data, w_io_stat;
  logic [AW-1:0] w_idx;

  assign w_is_io   = address[31];
  assign w_io_data = w_is_io && (address[30:2] == 29'd0);
  assign w_io_stat = w_is_io && (address[30:2] == 29'd1);
  assign w_idx     = address[AW+1:2];

  // ---------------------------------------------------------------------------
  // Store lane decode: byte enables plus data replicated into every lane, so
  // the enabled lanes always pick up the right bits. Misaligned or illegal
  // stores leave all enables low.
  // ---------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = data_in;
    case (func3)
      3'b000: begin
        w_be    = 4'b0001 << address[1:0];
        w_wdata = {4{data_in[7:0]}};
      end
      3'b001: begin
        if (!address[0]) begin
          w_be    = address[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{data_in[15:0]}};
        end
      end
      3'b010: begin
        if (address[1:0] == 2'b00) w_be = 4'b1111;
      end
      default: ;
    endcase
  end

  logic w_ram_we, w_led_we;
  assign w_ram_we = write_en && !w_is_io;
  assign w_led_we = write_en && w_io_data;

  // ---------------------------------------------------------------------------
  // RAM (never reset; contents survive reset pulses)
  // ---------------------------------------------------------------------------
  logic [31:0] r_mem [DEPTH_WORDS];

  // Keeps the file-name parameter referenced.
  localparam bit w_unused_init = (INIT_FILE == "");

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // LED register
  // ---------------------------------------------------------------------------
  logic [31:0] r_led;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led <= 32'd0;
    end else if (w_led_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_led[8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // UART transmitter FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_t;

  uart_st_t      r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_bit_done, w_uart_start, w_tx, w_busy;

  assign w_bit_done = (r_cnt == CNT_MAX);
  // Only a store that actually writes a lane of the data word starts a frame;
  // anything arriving mid-frame just updates the LEDs.
  assign w_uart_start = w_led_we && (w_be != 4'b0000) && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_uart_start) w_next = S_START;
      S_START: if (w_bit_done) w_next = S_DATA;
      S_DATA:  if (w_bit_done && (r_bit == 3'd7)) w_next = S_STOP;
      S_STOP:  if (w_bit_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_tx   = 1'b1;
    w_busy = 1'b0;
    case (r_state)
      S_START: begin w_tx = 1'b0;           w_busy = 1'b1; end
      S_DATA:  begin w_tx = r_shift[r_bit]; w_busy = 1'b1; end
      S_STOP:  begin w_tx = 1'b1;           w_busy = 1'b1; end
      default: ;
    endcase
  end

  // Bit timer, bit index and latched byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
    end else if (w_uart_start) begin
      r_shift <= data_in[7:0];
      r_cnt   <= '0;
      r_bit   <= 3'd0;
    end else if (r_state != S_IDLE) begin
      if (w_bit_done) begin
        r_cnt <= '0;
        if (r_state == S_DATA) r_bit <= r_bit + 3'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: fetch the word, shift the addressed lane down, then extend.
  // For aligned halfwords the byte shift equals the halfword shift.
  // ---------------------------------------------------------------------------
  logic [31:0] w_rword, w_rsh, w_load;

  always_comb begin
    if (w_is_io) begin
      if (w_io_data)      w_rword = r_led;
      else if (w_io_stat) w_rword = {31'd0, w_busy};
      else                w_rword = 32'd0;
    end else begin
      w_rword = r_mem[w_idx];
    end
  end

  assign w_rsh = w_rword >> {address[1:0], 3'b000};

  always_comb begin
    w_load = 32'd0;
    case (func3)
      3'b000: w_load = {{24{w_rsh[7]}}, w_rsh[7:0]};
      3'b100: w_load = {24'd0, w_rsh[7:0]};
      3'b001: if (!address[0]) w_load = {{16{w_rsh[15]}}, w_rsh[15:0]};
      3'b101: if (!address[0]) w_load = {16'd0, w_rsh[15:0]};
      3'b010: if (address[1:0] == 2'b00) w_load = w_rword;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response registers. A simultaneous store wins and the load reads back 0.
  // ---------------------------------------------------------------------------
  logic [31:0] r_data_out;
  logic        r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_out <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= read_en | write_en;
      if (read_en) r_data_out <= write_en ? 32'd0 : w_load;
    end
  end

  assign data_out    = r_data_out;
  assign valid       = r_valid;
  assign led_display = r_led;
  assign uart_output = w_tx;
  assign uart_busy   = w_busy;

endmodule

// File: tb/tb_main_memory.sv
module tb_main_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data_in = '0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] data_out;
  logic        valid;
  logic [31:0] led_display;
  logic        uart_output;
  logic        uart_busy;

  int n_chk = 0;
  int n_err = 0;

  main_memory dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_en(write_en), .read_en(read_en), .func3(func3),
    .data_out(data_out), .valid(valid), .led_display(led_display),
    .uart_output(uart_output), .uart_busy(uart_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One request cycle; returns on the negedge after the sampling posedge.
  task automatic acc(input logic we, input logic re, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] f);
    @(negedge clk);
    write_en = we; read_en = re; address = a; data_in = d; func3 = f;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f);
    acc(1'b1, 1'b0, a, d, f);
    chk({tag, "_v"}, {31'd0, valid}, 32'd1);
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] exp);
    acc(1'b0, 1'b1, a, 32'd0, f);
    chk(tag, data_out, exp);
    chk({tag, "_v"}, {31'd0, valid}, 32'd1);
  endtask

  // Called half a cycle after the frame-starting edge; samples mid-bit.
  task automatic uart_chk(input string tag, input logic [7:0] b);
    repeat (50) @(negedge clk);
    chk({tag, "_start"}, {31'd0, uart_output}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (100) @(negedge clk);
      chk($sformatf("%s_d%0d", tag, i), {31'd0, uart_output}, {31'd0, b[i]});
    end
    repeat (100) @(negedge clk);
    chk({tag, "_stop"}, {31'd0, uart_output}, 32'd1);
    repeat (49) @(negedge clk);
    chk({tag, "_busy999"}, {31'd0, uart_busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy1000"}, {31'd0, uart_busy}, 32'd0);
  endtask

  task automatic rst_pulse(input string tag);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk({tag, "_tx"},   {31'd0, uart_output}, 32'd1);
    chk({tag, "_busy"}, {31'd0, uart_busy},   32'd0);
    chk({tag, "_led"},  led_display,          32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_led",   led_display,          32'd0);
    chk("rst_tx",    {31'd0, uart_output}, 32'd1);
    chk("rst_busy",  {31'd0, uart_busy},   32'd0);
    chk("rst_valid", {31'd0, valid},       32'd0);
    chk("rst_dout",  data_out,             32'd0);

    // Byte store / loads
    st("sb1", 32'h1, 32'h01114444, 3'b000);
    acc(1'b0, 1'b1, 32'h0, 32'd0, 3'b010);
    chk("lw0_lane1", {24'd0, data_out[15:8]}, 32'h44);
    ld("lb1", 32'h1, 3'b000, 32'h00000044);
    st("sb1_80", 32'h1, 32'h00000080, 3'b000);
    ld("lb1_80",  32'h1, 3'b000, 32'hFFFFFF80);
    ld("lbu1_80", 32'h1, 3'b100, 32'h00000080);

    // Word store / halfword loads, misaligned and illegal loads
    st("sw8", 32'h8, 32'hDEADBEEF, 3'b010);
    ld("lh8",  32'h8, 3'b001, 32'hFFFFBEEF);
    ld("lhuA", 32'hA, 3'b101, 32'h0000DEAD);
    ld("lh9",  32'h9, 3'b001, 32'h00000000);
    ld("lw8",  32'h8, 3'b010, 32'hDEADBEEF);
    @(negedge clk);
    chk("hold_dout",  data_out,        32'hDEADBEEF);
    chk("hold_valid", {31'd0, valid},  32'd0);
    ld("lbB",    32'hB,    3'b000, 32'hFFFFFFDE);
    ld("lwA",    32'hA,    3'b010, 32'h00000000);
    ld("lw_alias", 32'h1008, 3'b010, 32'hDEADBEEF);
    ld("ld_f011", 32'h8,   3'b011, 32'h00000000);

    // Ignored stores
    st("swC",    32'hC, 32'h11223344, 3'b010);
    st("swE_mis", 32'hE, 32'hFFFFFFFF, 3'b010);
    st("shD_mis", 32'hD, 32'hFFFFFFFF, 3'b001);
    st("s_f011", 32'hC, 32'hFFFFFFFF, 3'b011);
    ld("lwC_a",  32'hC, 3'b010, 32'h11223344);
    st("shE",    32'hE, 32'hAAAA5555, 3'b001);
    ld("lwC_b",  32'hC, 3'b010, 32'h55553344);

    // Simultaneous read and write
    ld("lw8_pre", 32'h8, 3'b010, 32'hDEADBEEF);
    acc(1'b1, 1'b1, 32'h10, 32'h12345678, 3'b010);
    chk("rw_dout",  data_out,       32'd0);
    chk("rw_valid", {31'd0, valid}, 32'd1);
    ld("lw10", 32'h10, 3'b010, 32'h12345678);

    // Back-to-back loads
    @(negedge clk);
    read_en = 1'b1; address = 32'h8; func3 = 3'b010;
    @(negedge clk);
    address = 32'hC;
    chk("b2b0_v", {31'd0, valid}, 32'd1);
    chk("b2b0_d", data_out, 32'hDEADBEEF);
    @(negedge clk);
    read_en = 1'b0;
    chk("b2b1_v", {31'd0, valid}, 32'd1);
    chk("b2b1_d", data_out, 32'h55553344);
    @(negedge clk);
    chk("b2b2_v", {31'd0, valid}, 32'd0);

    // IO: LED + UART frame
    st("io_sb0", 32'h80000000, 32'h01114444, 3'b000);
    chk("io_led0",  led_display,        32'h00000044);
    chk("io_busy0", {31'd0, uart_busy}, 32'd1);
    uart_chk("f0", 8'h44);

    // Lanes 1..3, each preceded by a reset pulse
    for (int k = 1; k < 4; k++) begin
      rst_pulse($sformatf("rp%0d", k));
      st($sformatf("io_sb%0d", k), 32'h80000000 + k, 32'h01114444, 3'b000);
      chk($sformatf("io_led%0d", k), led_display, 32'h44 << (8 * k));
      chk($sformatf("io_busy%0d", k), {31'd0, uart_busy}, 32'd1);
      uart_chk($sformatf("f%0d", k), 8'h44);
      repeat (1000) @(negedge clk);
    end

    // Reset mid-frame: line is low (data bit 2 of 0x00), then returns high
    st("mid_sb", 32'h80000000, 32'h00000000, 3'b000);
    repeat (300) @(negedge clk);
    chk("mid_tx_lo", {31'd0, uart_output}, 32'd0);
    rst_pulse("mid_rst");
    ld("ram_kept", 32'h8, 3'b010, 32'hDEADBEEF);

    // Store while busy; status word
    st("bz_sw", 32'h80000000, 32'h000000A5, 3'b010);           // edge t0
    ld("stat_busy", 32'h80000004, 3'b010, 32'd1);
    st("bz_sh", 32'h80000002, 32'h00001234, 3'b001);
    ld("bz_led", 32'h80000000, 3'b010, 32'h123400A5);           // t0+6.5
    chk("bz_led_port", led_display, 32'h123400A5);
    repeat (993) @(negedge clk);
    chk("bz_busy999", {31'd0, uart_busy}, 32'd1);
    @(negedge clk);
    chk("bz_busy1000", {31'd0, uart_busy}, 32'd0);
    ld("stat_idle", 32'h80000004, 3'b010, 32'd0);

    // Unmapped IO offset
    st("io_other_st", 32'h80000008, 32'hFFFFFFFF, 3'b010);
    chk("io_other_led",  led_display,        32'h123400A5);
    chk("io_other_busy", {31'd0, uart_busy}, 32'd0);
    ld("io_other_ld", 32'h80000008, 3'b010, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
